// File: rtl/spu_fetch_unit.sv
// Dual-issue instruction fetch: byte-wide big-endian instruction memory, loaded
// through a write port, feeding 8-byte-aligned instruction pairs to decode.
module spu_fetch_unit #(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              start,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst0,
  output logic [31:0]       out_inst1,
  output logic              out_inst0_v,
  output logic              out_inst1_v,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       inst0_q, inst0_d;
  logic [31:0]       inst1_q, inst1_d;
  logic              inst0_v_q, inst0_v_d;
  logic              inst1_v_q, inst1_v_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic              halted_q, halted_d;
  logic [15:0]       count_q, count_d;

  logic [7:0] mem_q [IMEM_BYTES];

  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
    return {mem_q[a], mem_q[a + ADDR_W'(1)], mem_q[a + ADDR_W'(2)], mem_q[a + ADDR_W'(3)]};
  endfunction

  logic [ADDR_W-1:0] base;
  logic [31:0]       word_lo, word_hi;
  logic [31:0]       ld_i0, ld_i1;
  logic              ld_v0, ld_v1, stop0, stop1, ld_stop, hs;

  // An odd-slot pc is always base+4, so slot 1 reads the same word either way.
  always_comb begin
    base    = pc_q & ~ADDR_W'(7);
    word_lo = rd_word(base);
    word_hi = rd_word(base | ADDR_W'(4));
    ld_v0   = ~pc_q[2];
    ld_i0   = ld_v0 ? word_lo : '0;
    stop0   = ld_v0 && (word_lo == '0);
    ld_v1   = ~stop0;
    ld_i1   = stop0 ? '0 : word_hi;
    stop1   = ld_v1 && (word_hi == '0);
    ld_stop = stop0 || stop1;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    inst0_d   = inst0_q;
    inst1_d   = inst1_q;
    inst0_v_d = inst0_v_q;
    inst1_v_d = inst1_v_q;
    opc_d     = opc_q;
    halted_d  = halted_q;
    count_d   = count_q;

    hs = valid_q && out_ready;
    if (hs) begin
      valid_d = 1'b0;
      if (count_q != '1) count_d = count_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH, HALT: begin
        if (branch_valid) begin
          valid_d   = 1'b0;
          inst0_v_d = 1'b0;
          inst1_v_d = 1'b0;
          pc_d      = branch_target & ~ADDR_W'(3);
          state_d   = FETCH;
          halted_d  = 1'b0;
        end else if (state_q == FETCH) begin
          if (!valid_q || out_ready) begin
            valid_d   = 1'b1;
            inst0_d   = ld_i0;
            inst1_d   = ld_i1;
            inst0_v_d = ld_v0;
            inst1_v_d = ld_v1;
            opc_d     = base;
            pc_d      = base + ADDR_W'(8);
            if (ld_stop) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end
          end
        end else if (start) begin
          state_d  = FETCH;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      inst0_q   <= '0;
      inst1_q   <= '0;
      inst0_v_q <= 1'b0;
      inst1_v_q <= 1'b0;
      opc_q     <= '0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      inst0_q   <= inst0_d;
      inst1_q   <= inst1_d;
      inst0_v_q <= inst0_v_d;
      inst1_v_q <= inst1_v_d;
      opc_q     <= opc_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_inst0   = inst0_q;
  assign out_inst1   = inst1_q;
  assign out_inst0_v = inst0_v_q;
  assign out_inst1_v = inst1_v_q;
  assign out_pc      = opc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_spu_fetch_unit.sv
// Scoreboard bench for spu_fetch_unit: expected pairs are queued at stimulus
// time and a monitor compares each pair as decode accepts it.
module tb_spu_fetch_unit;
  localparam int unsigned AW = 10;
  localparam int unsigned NB = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          start;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst0, out_inst1;
  logic          out_inst0_v, out_inst1_v;
  logic [AW-1:0] out_pc;
  logic          halted;
  logic [15:0]   fetch_count;

  always #5 clk = ~clk;

  spu_fetch_unit #(.IMEM_BYTES(NB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .branch_valid(branch_valid),
    .branch_target(branch_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst0(out_inst0), .out_inst1(out_inst1), .out_inst0_v(out_inst0_v),
    .out_inst1_v(out_inst1_v), .out_pc(out_pc), .halted(halted),
    .fetch_count(fetch_count)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   i0;
    logic [31:0]   i1;
    logic          v0;
    logic          v1;
  } pair_t;

  pair_t      exp_q[$];
  logic [7:0] tb_mem [NB];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [31:0] mword(input logic [AW-1:0] a);
    return {tb_mem[a], tb_mem[a + 10'd1], tb_mem[a + 10'd2], tb_mem[a + 10'd3]};
  endfunction

  function automatic pair_t mpair(input logic [AW-1:0] pc);
    pair_t p;
    p.pc = {pc[AW-1:3], 3'b000};
    if (pc[2]) begin
      p.i0 = '0;
      p.v0 = 1'b0;
    end else begin
      p.i0 = mword(p.pc);
      p.v0 = 1'b1;
    end
    p.i1 = mword(p.pc + 10'd4);
    p.v1 = 1'b1;
    if (p.v0 && p.i0 == 32'h0) begin
      p.i1 = '0;
      p.v1 = 1'b0;
    end
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tb_mem[a] = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic push_run(input logic [AW-1:0] pc0, input int n);
    logic [AW-1:0] pc;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mpair(pc));
      pc = {pc[AW-1:3], 3'b000} + 10'd8;
    end
  endtask

  task automatic wait_halt_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted && !out_valid) break;
      tick();
    end
    checks++;
    if (!(halted && !out_valid)) begin
      errors++;
      $display("FAIL %s: timeout, halted=%b out_valid=%b required halted=1 out_valid=0",
               name, halted, out_valid);
    end
  endtask

  initial begin : monitor
    pair_t act, e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        act.pc = out_pc;
        act.i0 = out_inst0;
        act.i1 = out_inst1;
        act.v0 = out_inst0_v;
        act.v1 = out_inst1_v;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h with no pair expected", act.pc);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL sb_pair: got pc=%h i0=%h i1=%h v=%b%b expected pc=%h i0=%h i1=%h v=%b%b",
                     act.pc, act.i0, act.i1, act.v0, act.v1, e.pc, e.i0, e.i1, e.v0, e.v1);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] prog [8];
    prog = '{8'h18, 8'h0A, 8'h0F, 8'h14, 8'h31, 8'h00, 8'h05, 8'h32};
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; branch_valid = 1'b0; branch_target = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_count", fetch_count, 0);
    check("rst_pc", out_pc, 0);
    check("rst_flags", {out_inst0_v, out_inst1_v}, 0);
    check("rst_inst", out_inst0 | out_inst1, 0);
    reset = 1'b1;
    tick();

    for (int a = 0; a < NB; a++) wr(AW'(a), 8'((a * 37 + 11) | 1));
    for (int i = 0; i < 8; i++) wr(AW'(i), prog[i]);
    for (int i = 0; i < 4; i++) wr(AW'(32 + i), 8'h00);

    // Basic fetch, stall, then stream to the stop word at 0x020
    push_run(10'h000, 5);
    start = 1'b1; tick(); start = 1'b0;
    check("lat_e1_valid", out_valid, 0);
    tick();
    check("p0_valid", out_valid, 1);
    check("p0_inst0", out_inst0, 32'h180A0F14);
    check("p0_inst1", out_inst1, 32'h31000532);
    check("p0_flags", {out_inst0_v, out_inst1_v}, 2'b11);
    check("p0_pc", out_pc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_inst0", out_inst0, 32'h180A0F14);
      check("stall_inst1", out_inst1, 32'h31000532);
      check("stall_pc", out_pc, 0);
      check("stall_count", fetch_count, 0);
    end
    out_ready = 1'b1;
    tick();
    check("p1_pc", out_pc, 10'h008);
    check("p1_count", fetch_count, 1);
    start = 1'b1; tick(); start = 1'b0;
    wait_halt_idle("halt1", 20);
    check("halt1_count", fetch_count, 5);
    repeat (3) tick();
    check("halt1_hold_valid", out_valid, 0);
    check("halt1_hold_halted", halted, 1);

    // Restart from HALT, then redirect in the same cycle as a handshake
    out_ready = 1'b0;
    push_run(10'h000, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_halted", halted, 0);
    tick();
    check("restart_valid", out_valid, 1);
    check("restart_pc", out_pc, 0);
    push_run(10'h014, 3);
    out_ready = 1'b1; branch_valid = 1'b1; branch_target = 10'h014;
    tick();
    branch_valid = 1'b0;
    check("br_valid", out_valid, 0);
    check("br_flags", {out_inst0_v, out_inst1_v}, 0);
    check("br_count", fetch_count, 6);
    tick();
    check("br_pc", out_pc, 10'h010);
    check("br_v0", out_inst0_v, 0);
    check("br_inst0", out_inst0, 0);
    check("br_inst1", out_inst1, 32'hEF15395F);
    wait_halt_idle("halt2", 20);
    check("halt2_count", fetch_count, 9);

    // Redirect out of HALT near the top of memory; fetch wraps to 0
    push_run(10'h3F8, 6);
    branch_valid = 1'b1; branch_target = 10'h3FB;
    tick();
    branch_valid = 1'b0;
    check("brh_halted", halted, 0);
    check("brh_valid", out_valid, 0);
    tick();
    check("wrap_pre_pc", out_pc, 10'h3F8);
    tick();
    check("wrap_pc", out_pc, 10'h000);
    check("wrap_inst0", out_inst0, 32'h180A0F14);
    wait_halt_idle("halt3", 20);
    check("halt3_count", fetch_count, 15);

    // Asynchronous reset with a pair pending
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_halted", halted, 0);
    check("arst_count", fetch_count, 0);
    check("arst_pc", out_pc, 0);
    check("arst_flags", {out_inst0_v, out_inst1_v}, 0);
    tick();
    reset = 1'b1; out_ready = 1'b1;
    branch_valid = 1'b1; branch_target = 10'h014;
    tick();
    branch_valid = 1'b0;
    repeat (3) tick();
    check("idle_no_output", out_valid, 0);
    check("idle_count", fetch_count, 0);
    push_run(10'h000, 5);
    start = 1'b1; tick(); start = 1'b0;
    wait_halt_idle("halt4", 20);
    check("halt4_count", fetch_count, 5);

    tick();
    check("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
